// File: rtl/ahb_slave_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the ahb_slave_mem responder.
package ahb_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    function automatic logic trans_active(input logic [1:0] htrans);
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
            default:                   trans_active = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// DEPTH x 32 storage: synchronous write, asynchronous read.
module ahb_slave_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word memory slave with programmable wait states and read-after-write forwarding.
// Optional build macro WRITE_PROTECT_EN makes the upper quarter of the array read-only.
module ahb_slave_mem
    import ahb_slave_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hselx,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Hreadyout
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [3:0]    wait_cnt;

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          accept;
    logic          addr_err;
    logic          xfer_err;
    logic          we;
    logic          load_rd;
    logic [AW-1:0] raddr;
    logic [31:0]   ram_rdata;
    logic [31:0]   rdata_next;

    assign offset   = Haddr - BASE_ADDR;
    assign idx      = offset[AW+1:2];
    assign accept   = (state inside {ST_IDLE, ST_DATA, ST_ERR2}) && Hselx && Hreadyin
                      && trans_active(Htrans);
    assign addr_err = (Haddr < BASE_ADDR) || ((offset >> (AW + 2)) != '0) || (Haddr[1:0] != 2'b00);

`ifdef WRITE_PROTECT_EN
    localparam int unsigned PROT_START = 3 * DEPTH / 4;
    assign xfer_err = addr_err || (Hwrite && (32'(idx) >= PROT_START));
`else
    assign xfer_err = addr_err;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_WAIT: if (wait_cnt == '0) next_state = ST_DATA;
            ST_ERR1: next_state = ST_ERR2;
            default: begin
                if (!accept)       next_state = ST_IDLE;
                else if (xfer_err) next_state = ST_ERR1;
                else               next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
            end
        endcase
    end

    // Zero-wait reads load Hrdata at the accept edge itself, so the read index
    // comes straight from Haddr; a write committing that same edge is forwarded.
    assign we         = (state == ST_DATA) && write_q;
    assign load_rd    = (next_state == ST_DATA) && (accept ? !Hwrite : !write_q);
    assign raddr      = accept ? idx : addr_q;
    assign rdata_next = (we && (addr_q == raddr)) ? Hwdata : ram_rdata;

    ahb_slave_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (Hclk),
        .we    (we),
        .waddr (addr_q),
        .wdata (Hwdata),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wait_cnt  <= '0;
            Hrdata    <= '0;
            Hreadyout <= 1'b1;
            Hresp     <= HRESP_OKAY;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q  <= idx;
                write_q <= Hwrite;
            end
            if (accept && (next_state == ST_WAIT)) begin
                wait_cnt <= 4'(WAIT_STATES - 1);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (load_rd) begin
                Hrdata <= rdata_next;
            end
            Hreadyout <= !(next_state inside {ST_WAIT, ST_ERR1});
            Hresp     <= (next_state inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: zero, three and four wait-state instances on one shared bus.
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        hreset;
    logic        sel;
    int          cur;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;

    logic [31:0] rd0, rd3, rd4;
    logic [1:0]  rs0, rs3, rs4;
    logic        ro0, ro3, ro4;
    logic        bus_ready;
    logic [1:0]  bus_resp;
    logic [31:0] bus_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign bus_ready = (cur == 0) ? ro0 : (cur == 1) ? ro3 : ro4;
    assign bus_resp  = (cur == 0) ? rs0 : (cur == 1) ? rs3 : rs4;
    assign bus_rdata = (cur == 0) ? rd0 : (cur == 1) ? rd3 : rd4;

    ahb_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(0)) dut0 (
        .Hclk(clk), .Hreset(hreset), .Hselx(sel && cur == 0), .Hwrite(hwrite),
        .Hreadyin(bus_ready), .Htrans(htrans), .Haddr(haddr), .Hwdata(hwdata),
        .Hrdata(rd0), .Hresp(rs0), .Hreadyout(ro0));

    ahb_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3)) dut3 (
        .Hclk(clk), .Hreset(hreset), .Hselx(sel && cur == 1), .Hwrite(hwrite),
        .Hreadyin(bus_ready), .Htrans(htrans), .Haddr(haddr), .Hwdata(hwdata),
        .Hrdata(rd3), .Hresp(rs3), .Hreadyout(ro3));

    ahb_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(4)) dut4 (
        .Hclk(clk), .Hreset(hreset), .Hselx(sel && cur == 2), .Hwrite(hwrite),
        .Hreadyin(bus_ready), .Htrans(htrans), .Haddr(haddr), .Hwdata(hwdata),
        .Hrdata(rd4), .Hresp(rs4), .Hreadyout(ro4));

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // One NONSEQ transfer; returns after the final data-phase cycle has been sampled.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [1:0] resp,
                        output logic [1:0] resp_low, output int lows);
        @(negedge clk);
        sel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr;
        @(negedge clk);
        sel = 1'b0; htrans = 2'b00; hwdata = wd;
        lows = 0;
        resp_low = 2'b00;
        while (!bus_ready && lows < 40) begin
            if (lows == 0) resp_low = bus_resp;
            lows++;
            @(negedge clk);
        end
        rd   = bus_rdata;
        resp = bus_resp;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lows;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [1:0]  resp_low;
    int          lows;

    initial begin
        hreset = 1'b1; sel = 1'b0; cur = 0; htrans = 2'b00;
        hwrite = 1'b0; haddr = '0; hwdata = '0;

        #7;
        check("rst_ready", {31'b0, ro0}, 32'd1);
        check("rst_resp", {30'b0, rs0}, 32'd0);
        check("rst_rdata", rd0, 32'd0);
        #1 hreset = 1'b0;

        vecs.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         2'b00, 0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 2'b00, 0});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'h1111_1111, 32'h0,         2'b00, 0});
        vecs.push_back('{1'b1, 32'h8000_0002, 32'h2222_2222, 32'h0,         2'b01, 1});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         32'h1111_1111, 2'b00, 0});
        vecs.push_back('{1'b0, 32'h8000_0400, 32'h0,         32'h0,         2'b01, 1});
        vecs.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0,         2'b01, 1});
        vecs.push_back('{1'b1, 32'h8000_0020, 32'h0BAD_F00D, 32'h0,         2'b00, 0});
`ifdef WRITE_PROTECT_EN
        vecs.push_back('{1'b1, 32'h8000_02FC, 32'h0F0F_0F0F, 32'h0,         2'b00, 0});
        vecs.push_back('{1'b0, 32'h8000_02FC, 32'h0,         32'h0F0F_0F0F, 2'b00, 0});
`else
        vecs.push_back('{1'b1, 32'h8000_03FC, 32'hA5A5_A5A5, 32'h0,         2'b00, 0});
        vecs.push_back('{1'b0, 32'h8000_03FC, 32'h0,         32'hA5A5_A5A5, 2'b00, 0});
`endif

        cur = 0;
        foreach (vecs[i]) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, resp, resp_low, lows);
            check($sformatf("vec%0d_lows", i), 32'(lows), 32'(vecs[i].lows));
            check($sformatf("vec%0d_resp", i), {30'b0, resp}, {30'b0, vecs[i].resp});
            if (vecs[i].lows > 0)
                check($sformatf("vec%0d_resp_low", i), {30'b0, resp_low}, {30'b0, vecs[i].resp});
            if (!vecs[i].wr && vecs[i].resp == 2'b00)
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end

        // Pipelined write then read of the same word: read data must be forwarded.
        @(negedge clk);
        sel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8000_0020;
        @(negedge clk);
        hwdata = 32'h1234_5678; hwrite = 1'b0;
        check("pipe_wr_ready", {31'b0, bus_ready}, 32'd1);
        check("pipe_wr_resp", {30'b0, bus_resp}, 32'd0);
        @(negedge clk);
        sel = 1'b0; htrans = 2'b00;
        check("pipe_rd_ready", {31'b0, bus_ready}, 32'd1);
        check("pipe_rd_fwd", bus_rdata, 32'h1234_5678);
        xfer(1'b0, 32'h8000_0020, 32'h0, rd, resp, resp_low, lows);
        check("pipe_mem", rd, 32'h1234_5678);

        // BUSY while selected and NONSEQ while deselected are both ignored.
        @(negedge clk);
        sel = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h8000_0010; hwdata = 32'h0;
        @(negedge clk);
        check("busy_ready", {31'b0, bus_ready}, 32'd1);
        check("busy_resp", {30'b0, bus_resp}, 32'd0);
        sel = 1'b0; htrans = 2'b10;
        @(negedge clk);
        check("unsel_ready", {31'b0, bus_ready}, 32'd1);
        check("unsel_resp", {30'b0, bus_resp}, 32'd0);
        htrans = 2'b00;
        xfer(1'b0, 32'h8000_0010, 32'h0, rd, resp, resp_low, lows);
        check("busy_mem", rd, 32'hDEAD_BEEF);

`ifdef WRITE_PROTECT_EN
        xfer(1'b1, 32'h8000_0300, 32'h5A5A_5A5A, rd, resp, resp_low, lows);
        check("wp_lows", 32'(lows), 32'd1);
        check("wp_resp_low", {30'b0, resp_low}, 32'd1);
        check("wp_resp", {30'b0, resp}, 32'd1);
        xfer(1'b0, 32'h8000_0300, 32'h0, rd, resp, resp_low, lows);
        check("wp_rd_resp", {30'b0, resp}, 32'd0);
        check("wp_unchanged", {31'b0, rd != 32'h5A5A_5A5A}, 32'd1);
`endif

        // Three wait states.
        cur = 1;
        xfer(1'b1, 32'h8000_0004, 32'hCAFE_F00D, rd, resp, resp_low, lows);
        check("ws3_wr_lows", 32'(lows), 32'd3);
        check("ws3_wr_resp", {30'b0, resp}, 32'd0);
        xfer(1'b0, 32'h8000_0004, 32'h0, rd, resp, resp_low, lows);
        check("ws3_rd_lows", 32'(lows), 32'd3);
        check("ws3_rd_resp_low", {30'b0, resp_low}, 32'd0);
        check("ws3_rd_resp", {30'b0, resp}, 32'd0);
        check("ws3_rd_data", rd, 32'hCAFE_F00D);

        // Reset in the middle of a four-wait-state write discards it.
        cur = 2;
        xfer(1'b1, 32'h8000_0008, 32'h0102_0304, rd, resp, resp_low, lows);
        check("ws4_wr_lows", 32'(lows), 32'd4);
        xfer(1'b0, 32'h8000_0008, 32'h0, rd, resp, resp_low, lows);
        check("ws4_rd_data", rd, 32'h0102_0304);
        @(negedge clk);
        sel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8000_0008;
        @(negedge clk);
        sel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        check("ws4_pend_ready", {31'b0, bus_ready}, 32'd0);
        @(negedge clk);
        #2 hreset = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, bus_ready}, 32'd1);
        check("mid_rst_resp", {30'b0, bus_resp}, 32'd0);
        check("mid_rst_rdata", bus_rdata, 32'd0);
        @(negedge clk);
        hreset = 1'b0;
        xfer(1'b0, 32'h8000_0008, 32'h0, rd, resp, resp_low, lows);
        check("ws4_after_rst_lows", 32'(lows), 32'd4);
        check("ws4_after_rst_data", rd, 32'h0102_0304);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
